// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter: parity modes,
// transmit FSM states and elaboration-time helpers.
package uart_pkg;

    // Parity mode encodings used by the PARITY parameter
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Transmit FSM states, one per segment of the serial frame
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

    // Bit period in clk cycles, rounded to the nearest whole cycle
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    // Parity bit for a (zero-extended) payload: even parity is the XOR of
    // the data bits, odd parity is its inverse
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Pushes while full and pops while
// empty are ignored so the pointers can never run past each other.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array: written on an accepted push, contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at 2^AW; the count tracks push minus pop
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_framed_tx.sv
// Framed UART transmitter: bytes are queued in a FIFO and sent as
// start / data (LSB first) / optional parity / stop bits, frames back to
// back while the FIFO holds data. The serial line is driven from a flop.
module uart_framed_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 dout,
    output logic                 busy,
    output logic [FIFO_AW:0]     fifo_count
);

    localparam int DIV    = calc_div(CLK_FREQ, BAUD);
    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t              state_q, next_state;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   dout_q, dout_d;
    logic                   bit_end;
    logic                   start_frame;
    logic                   pop;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_rd_data;

    assign push     = in_valid && in_ready;
    assign in_ready = !fifo_full;
    assign dout     = dout_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;
    assign bit_end  = (baud_q == BAUD_LAST);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State, counters, shift register and the registered serial line
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= 1'b1;
        end else begin
            state_q <= next_state;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state logic; dout_d is the line level for the segment being entered
    always_comb begin
        next_state  = state_q;
        baud_d      = (state_q == IDLE || bit_end) ? '0 : baud_q + BAUD_W'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        dout_d      = dout_q;
        start_frame = 1'b0;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                dout_d      = 1'b1;
                start_frame = !fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    next_state = DATA;
                    bit_d      = '0;
                    dout_d     = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            next_state = PAR;
                            dout_d     = par_q;
                        end else begin
                            next_state = STOP;
                            dout_d     = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        dout_d  = shift_q[1];
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    next_state = STOP;
                    bit_d      = '0;
                    dout_d     = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        if (!fifo_empty) begin
                            start_frame = 1'b1;
                        end else begin
                            next_state = IDLE;
                            bit_d      = '0;
                            dout_d     = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                dout_d     = 1'b1;
            end
        endcase

        if (start_frame) begin
            pop        = 1'b1;
            next_state = START;
            baud_d     = '0;
            bit_d      = '0;
            shift_d    = fifo_rd_data;
            par_d      = parity_bit(8'(fifo_rd_data), PARITY);
            dout_d     = 1'b0;
        end
    end

endmodule

// File: doc/uart_framed_tx.md
UART_FRAMED_TX -- requirements
Module: uart_framed_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, the line rate in bit/s.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, legal range 5..8, the data bits per frame.
REQ-004 The block SHALL have parameter PARITY, default 0, the parity mode: 0 none, 1 odd, 2 even.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 The block SHALL have parameter FIFO_AW, default 4, giving a FIFO depth of 2^FIFO_AW bytes.
REQ-007 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-008 The block SHALL have port rst, input, 1 bit, a synchronous active-low reset.
REQ-009 The block SHALL have port in_valid, input, 1 bit, asserted when in_data holds a byte to send.
REQ-010 The block SHALL have port in_data, input, DATA_BITS wide, the payload.
REQ-011 The block SHALL have port in_ready, output, 1 bit, asserted while the FIFO is not full.
REQ-012 The block SHALL have port dout, output, 1 bit, the serial line, idle high.
REQ-013 The block SHALL have port busy, output, 1 bit, high while a frame is on the line or the FIFO is non-empty.
REQ-014 The block SHALL have port fifo_count, output, FIFO_AW+1 bits, the current FIFO occupancy.

Function
REQ-015 The bit period DIV SHALL be (CLK_FREQ + BAUD/2)/BAUD clk cycles, computed at elaboration; DIV=10417 with the defaults.
REQ-016 A push SHALL occur on any clk edge where in_valid and in_ready are both 1; in_data is captured on that edge.
REQ-017 in_ready SHALL be 0 exactly when fifo_count equals 2^FIFO_AW; writes while full are impossible by handshake.
REQ-018 A simultaneous push and pop SHALL leave fifo_count unchanged; FIFO pointers SHALL wrap modulo 2^FIFO_AW.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PAR, STOP.
REQ-020 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte and enter START; dout SHALL go low on the following edge.
REQ-021 Each of START, every DATA bit, PAR and every STOP bit SHALL hold dout constant for exactly DIV cycles.
REQ-022 DATA SHALL shift bits LSB first, DATA_BITS bits in total; PAR SHALL be skipped when PARITY=0.
REQ-023 The parity bit SHALL be the XOR of the data bits for even parity (PARITY=2) and its inverse for odd parity (PARITY=1).
REQ-024 STOP SHALL drive dout high for STOP_BITS*DIV cycles.
REQ-025 At the end of STOP with the FIFO non-empty, the FSM SHALL pop and enter START on the next edge with no idle gap; otherwise it SHALL return to IDLE.
REQ-026 A frame SHALL last exactly (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*DIV cycles.
REQ-027 Pushes during a frame SHALL NOT disturb the frame in progress.
REQ-028 dout SHALL be registered, with no combinational path from any input.

Reset
REQ-029 With rst=0 on a clk edge, the block SHALL set FSM=IDLE, dout=1, busy=0, fifo_count=0, in_ready=1 and clear the baud and bit counters.
REQ-030 Reset mid-frame SHALL abort the frame and discard the FIFO contents; dout SHALL be 1 on the edge after reset asserts.

Structure
REQ-031 The parity-mode encodings and FSM state encodings SHALL live in a shared package, uart_pkg.
REQ-032 The FIFO SHALL be one sub-module, sync_fifo, parametrised by width and address width; the FSM and baud counter SHALL remain in uart_framed_tx.

Verification
REQ-033 With CLK_FREQ=16, BAUD=1 (DIV=16), 8N1, pushing 0x55 SHALL produce dout 0,1,0,1,0,1,0,1,0,1 in 16-cycle bits, 160 cycles in total, then busy=0.
REQ-034 With PARITY=2, pushing 0x07 SHALL produce parity bit 1; with PARITY=1, pushing 0x03 SHALL produce parity bit 1, and the frame SHALL be 176 cycles.
REQ-035 With STOP_BITS=2, pushing 0xA3 then 0x3C back-to-back SHALL produce stop high for 32 cycles, and the second start bit SHALL begin on the next cycle.
REQ-036 With FIFO_AW=2, pushing 6 bytes continuously SHALL drop in_ready after the 5th accepted push (1 in flight plus 4 queued), and all 5 SHALL be sent in order.
REQ-037 Asserting rst=0 in the middle of DATA SHALL give dout=1, fifo_count=0 and FSM=IDLE on the next edge; a new push after release SHALL send a clean frame.
